// File: rtl/step_response_meter_if.sv
// Sample/stimulus and result signals exchanged between the step response meter and
// the harness driving it.
interface step_response_meter_if #(
    parameter int unsigned DATA_WIDTH = 21,
    parameter int unsigned CNT_WIDTH  = 31
);
    logic                  start;
    logic [DATA_WIDTH-1:0] initial_val;
    logic [DATA_WIDTH-1:0] final_val;
    logic [DATA_WIDTH-1:0] band;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample;
    logic                  busy;
    logic                  done;
    logic                  timed_out;
    logic [CNT_WIDTH-1:0]  rise_time;
    logic [CNT_WIDTH-1:0]  settle_time;
    logic [DATA_WIDTH-1:0] peak;
    logic                  overshoot;

    modport master (
        output start, initial_val, final_val, band, sample_valid, sample,
        input  busy, done, timed_out, rise_time, settle_time, peak, overshoot
    );

    modport slave (
        input  start, initial_val, final_val, band, sample_valid, sample,
        output busy, done, timed_out, rise_time, settle_time, peak, overshoot
    );
endinterface

// File: rtl/step_response_meter.sv
// Step response meter: timestamps rise and settling of a sampled plant output after a
// step, tracks the peak in the step direction and flags overshoot or timeout.
module step_response_meter #(
    parameter int unsigned DATA_WIDTH  = 21,
    parameter int unsigned CNT_WIDTH   = 31,
    parameter int unsigned SETTLE_HOLD = 16,
    parameter int unsigned TIMEOUT     = 100000
) (
    input logic                 clk,
    input logic                 rst_n,
    step_response_meter_if.slave bus
);
    localparam int unsigned HoldW = $clog2(SETTLE_HOLD + 1);
    localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT);
    localparam logic [HoldW-1:0]     HoldVal    = HoldW'(SETTLE_HOLD);

    typedef enum logic [1:0] {StIdle, StRise, StSettle} state_e;

    state_e                r_state, w_state_d;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
    logic [CNT_WIDTH-1:0]  r_cand, w_cand_d;
    logic [CNT_WIDTH-1:0]  r_rise, w_rise_d;
    logic [CNT_WIDTH-1:0]  r_settle, w_settle_d;
    logic [HoldW-1:0]      r_hold, w_hold_d;
    logic [DATA_WIDTH-1:0] r_final, w_final_d;
    logic [DATA_WIDTH-1:0] r_band, w_band_d;
    logic [DATA_WIDTH-1:0] r_peak, w_peak_d;
    logic                  r_dir_up, w_dir_up_d;
    logic                  r_overshoot, w_overshoot_d;
    logic                  r_timed_out, w_timed_out_d;
    logic                  r_done, w_done_d;

    logic [DATA_WIDTH:0]   w_samp_x, w_final_x, w_diff, w_peak_new_x;
    logic [DATA_WIDTH-1:0] w_peak_new;
    logic                  w_in_band, w_hit, w_over_new, w_complete;
    logic [HoldW-1:0]      w_hold_inc;

    // Band test and overshoot compare are done one bit wider so nothing wraps.
    assign w_samp_x     = {1'b0, bus.sample};
    assign w_final_x    = {1'b0, r_final};
    assign w_diff       = (w_samp_x >= w_final_x) ? (w_samp_x - w_final_x) : (w_final_x - w_samp_x);
    assign w_in_band    = (w_diff <= {1'b0, r_band});
    assign w_hit        = bus.sample_valid && w_in_band;
    assign w_hold_inc   = r_hold + 1'b1;
    assign w_peak_new   = r_dir_up ? ((bus.sample > r_peak) ? bus.sample : r_peak)
                                   : ((bus.sample < r_peak) ? bus.sample : r_peak);
    assign w_peak_new_x = {1'b0, w_peak_new};
    assign w_over_new   = r_dir_up ? (w_peak_new_x > (w_final_x + {1'b0, r_band}))
                                   : ((w_peak_new_x + {1'b0, r_band}) < w_final_x);

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_cand_d      = r_cand;
        w_rise_d      = r_rise;
        w_settle_d    = r_settle;
        w_hold_d      = r_hold;
        w_final_d     = r_final;
        w_band_d      = r_band;
        w_peak_d      = r_peak;
        w_dir_up_d    = r_dir_up;
        w_overshoot_d = r_overshoot;
        w_timed_out_d = r_timed_out;
        w_done_d      = 1'b0;
        w_complete    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_final_d     = bus.final_val;
                    w_band_d      = bus.band;
                    w_dir_up_d    = (bus.final_val >= bus.initial_val);
                    w_peak_d      = bus.initial_val;
                    w_cnt_d       = '0;
                    w_cand_d      = '0;
                    w_hold_d      = '0;
                    w_rise_d      = '0;
                    w_settle_d    = '0;
                    w_overshoot_d = 1'b0;
                    w_timed_out_d = 1'b0;
                    w_state_d     = StRise;
                end
            end
            StRise, StSettle: begin
                w_cnt_d = r_cnt + 1'b1;
                if (bus.sample_valid) begin
                    w_peak_d      = w_peak_new;
                    w_overshoot_d = w_over_new;
                end
                if (r_state == StRise) begin
                    if (w_hit) begin
                        w_rise_d  = r_cnt;
                        w_cand_d  = r_cnt;
                        w_hold_d  = HoldW'(1);
                        w_state_d = StSettle;
                        if (SETTLE_HOLD == 1) begin
                            w_settle_d = r_cnt;
                            w_complete = 1'b1;
                        end
                    end
                end else if (bus.sample_valid) begin
                    if (w_in_band) begin
                        if (r_hold == '0) w_cand_d = r_cnt;
                        w_hold_d = w_hold_inc;
                        if (w_hold_inc == HoldVal) begin
                            w_settle_d = (r_hold == '0) ? r_cnt : r_cand;
                            w_complete = 1'b1;
                        end
                    end else begin
                        w_hold_d = '0;
                    end
                end
                if (w_complete) begin
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end else if (r_cnt == TimeoutVal) begin
                    w_done_d      = 1'b1;
                    w_timed_out_d = 1'b1;
                    w_settle_d    = '1;
                    if (r_state == StRise && !w_hit) w_rise_d = '1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_rise      <= '0;
            r_settle    <= '0;
            r_hold      <= '0;
            r_final     <= '0;
            r_band      <= '0;
            r_peak      <= '0;
            r_dir_up    <= 1'b0;
            r_overshoot <= 1'b0;
            r_timed_out <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_cand      <= w_cand_d;
            r_rise      <= w_rise_d;
            r_settle    <= w_settle_d;
            r_hold      <= w_hold_d;
            r_final     <= w_final_d;
            r_band      <= w_band_d;
            r_peak      <= w_peak_d;
            r_dir_up    <= w_dir_up_d;
            r_overshoot <= w_overshoot_d;
            r_timed_out <= w_timed_out_d;
            r_done      <= w_done_d;
        end
    end

    assign bus.busy        = (r_state != StIdle);
    assign bus.done        = r_done;
    assign bus.timed_out   = r_timed_out;
    assign bus.rise_time   = r_rise;
    assign bus.settle_time = r_settle;
    assign bus.peak        = r_peak;
    assign bus.overshoot   = r_overshoot;
endmodule

// File: tb/tb_step_response_meter.sv
// Directed bench for step_response_meter: clean, ringing, falling, timeout, sparse-valid,
// ignored re-start and mid-measurement reset scenarios.
module tb_step_response_meter;
    localparam int unsigned DW = 21;
    localparam int unsigned CW = 31;
    localparam logic [63:0] Ones = 64'h7fff_ffff;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   dn;

    step_response_meter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    step_response_meter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .SETTLE_HOLD(4),
        .TIMEOUT    (50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] samp(input int t, input int n);
        case (t)
            1: begin
                if (n < 10) return 20;
                case (n)
                    11: return 106;
                    12: return 99;
                    13: return 101;
                    default: return 100;
                endcase
            end
            2: return (n == 0) ? 21'd100 : (n == 1) ? 21'd50 : (n == 2) ? 21'd19 : 21'd20;
            3: return 20;
            4: begin
                if (n % 3 != 0) return 101;
                return (n < 9) ? 21'd20 : 21'd100;
            end
            default: return (n < 10) ? 21'd20 : 21'd100;
        endcase
    endfunction

    task automatic start_meas(input logic [DW-1:0] iv, input logic [DW-1:0] fv,
                              input logic [DW-1:0] bd);
        bus.start       = 1'b1;
        bus.initial_val = iv;
        bus.final_val   = fv;
        bus.band        = bd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("busy_after_start", {63'd0, bus.busy}, 64'd1);
        check_eq("done_one_cycle", {63'd0, bus.done}, 64'd0);
    endtask

    // Drives the sample for cnt=n each cycle; returns the cnt whose edge raised done.
    task automatic run(input int t, input int maxn, output int done_n);
        done_n = -1;
        for (int n = 0; n < maxn; n++) begin
            bus.sample_valid = (t == 4) ? (n % 3 == 0) : 1'b1;
            bus.sample       = samp(t, n);
            if (t == 5 && n == 5) begin
                bus.start       = 1'b1;
                bus.initial_val = 0;
                bus.final_val   = 50;
                bus.band        = 1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_n = n;
                break;
            end
        end
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input int done_n, input int exp_dn,
                             input logic [63:0] rise, input logic [63:0] settle,
                             input logic [63:0] pk, input logic ov, input logic to);
        check_eq({tag, "_done_cnt"}, 64'(done_n), 64'(exp_dn));
        check_eq({tag, "_rise"}, 64'(bus.rise_time), rise);
        check_eq({tag, "_settle"}, 64'(bus.settle_time), settle);
        check_eq({tag, "_peak"}, 64'(bus.peak), pk);
        check_eq({tag, "_overshoot"}, {63'd0, bus.overshoot}, {63'd0, ov});
        check_eq({tag, "_timed_out"}, {63'd0, bus.timed_out}, {63'd0, to});
        check_eq({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, bus.done}, 64'd0);
        check_eq({tag, "_timed_out"}, {63'd0, bus.timed_out}, 64'd0);
        check_eq({tag, "_rise"}, 64'(bus.rise_time), 64'd0);
        check_eq({tag, "_settle"}, 64'(bus.settle_time), 64'd0);
        check_eq({tag, "_peak"}, 64'(bus.peak), 64'd0);
        check_eq({tag, "_overshoot"}, {63'd0, bus.overshoot}, 64'd0);
    endtask

    initial begin
        logic seen;
        n_cmp            = 0;
        n_err            = 0;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.initial_val  = '0;
        bus.final_val    = '0;
        bus.band         = '0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        #2;
        check_zero("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_meas(20, 100, 2);
        run(0, 200, dn);
        check_res("clean", dn, 13, 10, 10, 100, 1'b0, 1'b0);

        // Next start lands in the done cycle of the previous measurement.
        start_meas(20, 100, 2);
        run(1, 200, dn);
        check_res("ring", dn, 15, 10, 12, 106, 1'b1, 1'b0);

        start_meas(100, 20, 0);
        run(2, 200, dn);
        check_res("fall", dn, 6, 3, 3, 19, 1'b1, 1'b0);

        start_meas(20, 100, 2);
        run(3, 200, dn);
        check_res("timeout", dn, 50, Ones, Ones, 20, 1'b0, 1'b1);

        start_meas(20, 100, 2);
        check_eq("restart_clears_timed_out", {63'd0, bus.timed_out}, 64'd0);
        check_eq("restart_clears_rise", 64'(bus.rise_time), 64'd0);
        run(4, 200, dn);
        check_res("sparse", dn, 18, 9, 9, 100, 1'b0, 1'b0);

        start_meas(20, 100, 2);
        run(5, 200, dn);
        check_res("start_busy", dn, 13, 10, 10, 100, 1'b0, 1'b0);

        start_meas(20, 100, 2);
        run(0, 13, dn);
        check_eq("pre_reset_no_done", 64'(dn), 64'hffff_ffff_ffff_ffff);
        check_eq("pre_reset_rise", 64'(bus.rise_time), 64'd10);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check_eq("mid_reset_no_done", {63'd0, seen}, 64'd0);
        check_zero("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
